rle_encoder: RTL and testbench
==============================

RLE_ENCODER -- requirements
Module: rle_encoder

Interface
REQ-001 The block SHALL expose these ports, one per line: name  direction  width  meaning.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream byte present on in_data.
REQ-005 in_data  input  8  raw symbol byte.
REQ-006 in_last  input  1  qualifies the current byte as the final byte of a message; flush after it.
REQ-007 in_ready  output  1  block accepts in_data this cycle; accept = in_valid & in_ready.
REQ-008 full  input  1  downstream decode FIFO full; no write while high.
REQ-009 wr_en  output  1  write strobe to the downstream decode FIFO, one pair per high cycle.
REQ-010 data_din  output  8  symbol of the emitted (symbol, count) pair.
REQ-011 data_cin  output  4  run length of the emitted pair, range 1..15.
REQ-012 Parameters: DATA_W, default 8, symbol width; CNT_W, default 4, count width; CNT_MAX, default 15, largest emitted run.

Function
REQ-013 The block SHALL run-length encode the accepted byte stream into (symbol, count) pairs, and the downstream decode FIFO SHALL reproduce the stream exactly from those pairs.
REQ-014 State machine: IDLE (no open run) and RUN (open run in run_sym/run_cnt); a single-entry hold register (hold_valid, hold_sym, hold_cnt) buffers one finished pair.
REQ-015 in_ready = ~hold_valid, combinational; a byte is never accepted while a finished pair is pending.
REQ-016 IDLE + accept: run_sym<=in_data, run_cnt<=1, go RUN; with in_last also high, pair (in_data,1) goes directly to hold and state stays IDLE.
REQ-017 RUN + accept, in_data==run_sym and run_cnt<CNT_MAX: run_cnt<=run_cnt+1.
REQ-018 RUN + accept, in_data!=run_sym or run_cnt==CNT_MAX: hold<=(run_sym,run_cnt), run_sym<=in_data, run_cnt<=1, stay RUN.
REQ-019 RUN + accept with in_last: the byte is merged per REQ-017/018; the resulting open run SHALL be pushed to hold and state goes IDLE; if REQ-018 also applies, the second pair is pushed in the following free hold slot before IDLE (a FLUSH state is permitted for this).
REQ-020 wr_en = hold_valid & ~full, combinational; data_din/data_cin = hold_sym/hold_cnt; hold_valid clears on the edge where wr_en is high.
REQ-021 Latency: a pair SHALL appear on wr_en the cycle after the edge that finished it, provided full is low.
REQ-022 full high: wr_en stays 0, pair and data_din/data_cin held stable, in_ready 0; no pair is dropped or duplicated.
REQ-023 A count of 0 SHALL never be emitted; count arithmetic never wraps, saturating via REQ-018 at CNT_MAX.
REQ-024 in_valid low in RUN: run held indefinitely; no timeout flush.

Reset
REQ-025 RST high at a rising edge: state<=IDLE, hold_valid<=0, run_cnt<=0, run_sym<=0, hold_sym<=0, hold_cnt<=0; thus wr_en=0, in_ready=1, data_din=0, data_cin=0.
REQ-026 RST mid-run or with a pending pair SHALL discard both; no wr_en in the reset cycle or the cycle after.

Structure
REQ-027 Package rle_pkg SHALL hold DATA_W, CNT_W, CNT_MAX and the state enum, shared with the decode FIFO.
REQ-028 One sub-module is natural: rle_pair_reg (hold register + wr_en/full handshake); run tracking and FSM stay in rle_encoder.

Verification
REQ-029 Bytes 97,97,97,98,98,99(last), full=0 -> pairs (97,3),(98,2),(99,1) in order, then IDLE.
REQ-030 Seventeen 97s, last on 17th -> pairs (97,15),(97,2).
REQ-031 full=1 while pair (100,2) pending for 5 cycles -> wr_en=0, in_ready=0, data_din=100/data_cin=2 stable; full=0 -> exactly one wr_en pulse.
REQ-032 Single byte 101 with in_last from IDLE -> one pair (101,1) next cycle.
REQ-033 RST asserted after 97,97 accepted -> no pair emitted; then 98(last) -> only (98,1).
REQ-034 End-to-end: rle_encoder feeding DECODE_FIFO, random bytes with runs 1..20 -> decoded data_o stream equals input stream.

Source files
------------

// File: rtl/rle_pkg.sv
// Shared widths, limits and FSM state type for the RLE encoder and its decode FIFO.
package rle_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = 15;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush
  } rle_state_e;

endpackage

// File: rtl/rle_encoder_if.sv
// Byte-stream input and (symbol, count) pair output bundle of the RLE encoder.
interface rle_encoder_if #(
  parameter int unsigned DATA_W = rle_pkg::DATA_W,
  parameter int unsigned CNT_W  = rle_pkg::CNT_W
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              full;
  logic              wr_en;
  logic [DATA_W-1:0] data_din;
  logic [CNT_W-1:0]  data_cin;

  modport master (
    input  in_valid, in_data, in_last, full,
    output in_ready, wr_en, data_din, data_cin
  );

  modport slave (
    output in_valid, in_data, in_last, full,
    input  in_ready, wr_en, data_din, data_cin
  );

endinterface

// File: rtl/rle_pair_reg.sv
// Single-entry hold register for one finished (symbol, count) pair and its FIFO write handshake.
module rle_pair_reg #(
  parameter int unsigned DATA_W = rle_pkg::DATA_W,
  parameter int unsigned CNT_W  = rle_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_sym,
  input  logic [CNT_W-1:0]  push_cnt,
  input  logic              full,
  output logic              hold_valid,
  output logic              wr_en,
  output logic [DATA_W-1:0] data_din,
  output logic [CNT_W-1:0]  data_cin
);

  logic              valid_q;
  logic [DATA_W-1:0] sym_q;
  logic [CNT_W-1:0]  cnt_q;

  // Reset masks the strobe so a pending pair never leaks out in the reset cycle.
  assign wr_en      = valid_q & ~full & ~rst;
  assign hold_valid = valid_q;
  assign data_din   = sym_q;
  assign data_cin   = cnt_q;

  // The encoder only pushes into a free slot, so push never collides with a held pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sym_q   <= '0;
      cnt_q   <= '0;
    end else if (push) begin
      valid_q <= 1'b1;
      sym_q   <= push_sym;
      cnt_q   <= push_cnt;
    end else if (wr_en) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/rle_encoder.sv
// Run-length encoder: tracks the open run and hands finished pairs to rle_pair_reg.
module rle_encoder
  import rle_pkg::*;
#(
  parameter int unsigned DATA_W  = rle_pkg::DATA_W,
  parameter int unsigned CNT_W   = rle_pkg::CNT_W,
  parameter int unsigned CNT_MAX = rle_pkg::CNT_MAX
) (
  input logic                 CLK,
  input logic                 RST,
  rle_encoder_if.master       bus
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  rle_state_e        state_q;
  logic [DATA_W-1:0] run_sym_q;
  logic [CNT_W-1:0]  run_cnt_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic              hold_valid;
  logic              accept;
  logic              extend;
  logic              push;
  logic [DATA_W-1:0] push_sym;
  logic [CNT_W-1:0]  push_cnt;

  // FLUSH owns the next free slot, so no new byte may enter while it is pending.
  assign bus.in_ready = ~hold_valid & (state_q != StFlush);
  assign accept       = bus.in_valid & bus.in_ready;
  assign cnt_inc      = run_cnt_q + CntOne;
  assign extend       = (bus.in_data == run_sym_q) && (run_cnt_q < CntMax);

  always_comb begin
    push     = 1'b0;
    push_sym = run_sym_q;
    push_cnt = run_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept && bus.in_last) begin
          push     = 1'b1;
          push_sym = bus.in_data;
          push_cnt = CntOne;
        end
      end
      StRun: begin
        if (accept) begin
          if (extend) begin
            push     = bus.in_last;
            push_cnt = cnt_inc;
          end else begin
            push = 1'b1;
          end
        end
      end
      StFlush: push = ~hold_valid;
      default: push = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      run_sym_q <= '0;
      run_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (bus.in_last) begin
              run_cnt_q <= '0;
            end else begin
              run_sym_q <= bus.in_data;
              run_cnt_q <= CntOne;
              state_q   <= StRun;
            end
          end
        end
        StRun: begin
          if (accept) begin
            if (extend) begin
              if (bus.in_last) begin
                run_cnt_q <= '0;
                state_q   <= StIdle;
              end else begin
                run_cnt_q <= cnt_inc;
              end
            end else begin
              run_sym_q <= bus.in_data;
              run_cnt_q <= CntOne;
              if (bus.in_last) state_q <= StFlush;
            end
          end
        end
        StFlush: begin
          if (!hold_valid) begin
            run_cnt_q <= '0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  rle_pair_reg #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_pair_reg (
    .clk        (CLK),
    .rst        (RST),
    .push       (push),
    .push_sym   (push_sym),
    .push_cnt   (push_cnt),
    .full       (bus.full),
    .hold_valid (hold_valid),
    .wr_en      (bus.wr_en),
    .data_din   (bus.data_din),
    .data_cin   (bus.data_cin)
  );

endmodule

// File: tb/tb_rle_encoder.sv
// Directed bench for rle_encoder: pair order, saturation, backpressure, reset and decode round-trip.
module tb_rle_encoder;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [11:0] pairs[$];

  rle_encoder_if bus ();

  rle_encoder u_dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every written pair is logged as {symbol, count}.
  always @(negedge clk) begin
    if (bus.wr_en) pairs.push_back({bus.data_din, bus.data_cin});
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    bit done;
    int n;
    done = 1'b0;
    n    = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!done && n < 64) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) check_eq("accept_timeout", 0, 1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_pairs(input string tag, input logic [11:0] exp[$]);
    check_eq({tag, "_npairs"}, pairs.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      check_eq($sformatf("%s_pair%0d", tag, i),
               (i < pairs.size()) ? int'(pairs[i]) : 32'hffff_ffff, int'(exp[i]));
    end
    pairs.delete();
  endtask

  initial begin
    logic [7:0]  run_sym[7];
    int          run_len[7];
    logic [7:0]  stream[$];
    logic [7:0]  decoded[$];
    n_cmp = 0;
    n_err = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.full     = 1'b0;
    idle_cycles(2);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_wr_en", bus.wr_en, 0);
    check_eq("rst_in_ready", bus.in_ready, 1);
    check_eq("rst_din", bus.data_din, 0);
    check_eq("rst_cin", bus.data_cin, 0);
    @(posedge clk);
    #1;

    // Mixed runs ending in a singleton flush.
    send(97, 0); send(97, 0); send(97, 0); send(98, 0); send(98, 0); send(99, 1);
    idle_cycles(6);
    expect_pairs("basic", '{{8'd97, 4'd3}, {8'd98, 4'd2}, {8'd99, 4'd1}});
    @(negedge clk);
    check_eq("basic_idle_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Saturation at 15, remainder flushed on last.
    for (int i = 0; i < 17; i++) send(97, i == 16);
    idle_cycles(6);
    expect_pairs("sat", '{{8'd97, 4'd15}, {8'd97, 4'd2}});

    // Single byte with last: pair visible the cycle right after acceptance.
    send(101, 1);
    @(negedge clk);
    check_eq("single_wr_en", bus.wr_en, 1);
    check_eq("single_din", bus.data_din, 101);
    check_eq("single_cin", bus.data_cin, 1);
    idle_cycles(4);
    expect_pairs("single", '{{8'd101, 4'd1}});

    // Run change coinciding with last needs two pushes.
    send(97, 0); send(97, 0); send(98, 1);
    idle_cycles(6);
    expect_pairs("flush2", '{{8'd97, 4'd2}, {8'd98, 4'd1}});

    // Backpressure holds the pending pair stable.
    bus.full = 1'b1;
    send(100, 0); send(100, 0); send(102, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq($sformatf("full_wr_en%0d", i), bus.wr_en, 0);
      check_eq($sformatf("full_ready%0d", i), bus.in_ready, 0);
      check_eq($sformatf("full_din%0d", i), bus.data_din, 100);
      check_eq($sformatf("full_cin%0d", i), bus.data_cin, 2);
      @(posedge clk);
      #1;
    end
    bus.full = 1'b0;
    idle_cycles(4);
    expect_pairs("full", '{{8'd100, 4'd2}});
    send(102, 1);
    idle_cycles(4);
    expect_pairs("full_close", '{{8'd102, 4'd2}});

    // Reset discards an open run.
    send(97, 0); send(97, 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_run_wr_en", bus.wr_en, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_run_wr_en_after", bus.wr_en, 0);
    @(posedge clk);
    #1;
    send(98, 1);
    idle_cycles(4);
    expect_pairs("rst_run", '{{8'd98, 4'd1}});

    // Reset discards a pending pair held back by full.
    bus.full = 1'b1;
    send(97, 0); send(98, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    bus.full = 1'b0;
    idle_cycles(4);
    check_eq("rst_pend_npairs", pairs.size(), 0);
    pairs.delete();

    // Round trip through a pair expander.
    run_sym = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16};
    run_len = '{1, 20, 3, 15, 16, 1, 2};
    for (int r = 0; r < 7; r++)
      for (int k = 0; k < run_len[r]; k++) stream.push_back(run_sym[r]);
    for (int i = 0; i < stream.size(); i++) send(stream[i], i == stream.size() - 1);
    idle_cycles(8);
    check_eq("e2e_npairs", pairs.size(), 9);
    foreach (pairs[i]) begin
      if (pairs[i][3:0] == 4'd0) check_eq("e2e_zero_cnt", 0, 1);
      for (int k = 0; k < int'(pairs[i][3:0]); k++) decoded.push_back(pairs[i][11:4]);
    end
    check_eq("e2e_len", decoded.size(), stream.size());
    for (int i = 0; i < stream.size(); i++) begin
      check_eq($sformatf("e2e_byte%0d", i),
               (i < decoded.size()) ? int'(decoded[i]) : 32'hffff_ffff, int'(stream[i]));
    end
    pairs.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
